e_md_ctrl: RTL and testbench

E-stage sequencer for the shared multiply/divide unit and its HI/LO register pair. Turns E-stage mult/multu/div/divu/mthi/mtlo instructions into a `start` pulse, counts the operation latency and drives `busy`. Issues the HI/LO write enables at commit and stalls the D stage whenever a HI/LO-dependent instruction would collide with an operation in flight. Sits beside the multiply/divide datapath; the datapath computes, this block decides when.

---
 rtl/e_md_ctrl.sv | 126 ++++++++++++
 tb/tb_e_md_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_md_ctrl.sv
// e_md_ctrl: E-stage sequencer for the shared multiply/divide unit.
// Issues the datapath start pulse, times the operation, generates the
// HI/LO write enables at commit and stalls D around in-flight operations.
module e_md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,       // asynchronous, active-low
    input  logic       e_md_valid,
    input  logic [3:0] e_md_op,
    input  logic       e_flush,
    input  logic       d_md_use,
    output logic       start,
    output logic [3:0] dp_op,
    output logic       busy,
    output logic       hi_we,
    output logic       lo_we,
    output logic       wb_sel,
    output logic       done,
    output logic       stall
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dp_op_q, dp_op_d;

    logic is_md_op;
    logic is_div_op;
    logic is_mt_op;
    logic acc_md;
    logic acc_mt;
    logic commit;

    // Decode the E-stage opcode into accepted requests; a flush kills the request outright.
    always_comb begin
        is_md_op  = (e_md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
        is_div_op = (e_md_op inside {OP_DIV, OP_DIVU});
        is_mt_op  = (e_md_op inside {OP_MTHI, OP_MTLO});
        acc_md    = e_md_valid & is_md_op & ~e_flush;
        acc_mt    = e_md_valid & is_mt_op & ~e_flush;
        commit    = (state_q == RUN) && (cnt_q == CNT_W'(1));
    end

    // Next-state logic: launch from IDLE, count down in RUN, return to IDLE after commit.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_op_d = dp_op_q;
        unique case (state_q)
            IDLE: begin
                if (acc_md) begin
                    state_d = RUN;
                    dp_op_d = e_md_op;
                    cnt_d   = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                // Requests arriving here are ignored; flushes cannot cancel an issued op.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode, forced low while reset is asserted so nothing leaks out during reset.
    always_comb begin
        start  = 1'b0;
        busy   = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wb_sel = 1'b0;
        done   = 1'b0;
        if (reset) begin
            if (state_q == IDLE) begin
                start = acc_md;
                hi_we = acc_mt & (e_md_op == OP_MTHI);
                lo_we = acc_mt & (e_md_op == OP_MTLO);
            end else begin
                busy = 1'b1;
                if (commit) begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    wb_sel = 1'b1;
                    done   = 1'b1;
                end
            end
        end
        stall = d_md_use & (start | busy);
        dp_op = dp_op_q;
    end

    // State, counter and latched opcode registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dp_op_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_op_q <= dp_op_d;
        end
    end

endmodule

// File: tb/tb_e_md_ctrl.sv
// tb_e_md_ctrl: directed self-checking bench for e_md_ctrl with default
// parameters (MULT_CYCLES = 5, DIV_CYCLES = 10).
module tb_e_md_ctrl;

    logic       clk;
    logic       reset;
    logic       e_md_valid;
    logic [3:0] e_md_op;
    logic       e_flush;
    logic       d_md_use;
    logic       start;
    logic [3:0] dp_op;
    logic       busy;
    logic       hi_we;
    logic       lo_we;
    logic       wb_sel;
    logic       done;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;

    e_md_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .e_md_valid(e_md_valid),
        .e_md_op   (e_md_op),
        .e_flush   (e_flush),
        .d_md_use  (d_md_use),
        .start     (start),
        .dp_op     (dp_op),
        .busy      (busy),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wb_sel    (wb_sel),
        .done      (done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks every single-bit output of the current cycle.
    task automatic expect_outs(input string tag, input logic s, input logic b, input logic h,
                               input logic l, input logic w, input logic d, input logic st);
        check({tag, ".start"},  start,  s);
        check({tag, ".busy"},   busy,   b);
        check({tag, ".hi_we"},  hi_we,  h);
        check({tag, ".lo_we"},  lo_we,  l);
        check({tag, ".wb_sel"}, wb_sel, w);
        check({tag, ".done"},   done,   d);
        check({tag, ".stall"},  stall,  st);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic fl, input logic use_d);
        e_md_valid = v;
        e_md_op    = op;
        e_flush    = fl;
        d_md_use   = use_d;
    endtask

    // Issue one mult/div at cycle t and check t .. t+n+1. Leaves inputs idle at t+n+1.
    task automatic run_md(input string tag, input logic [3:0] op, input int n, input logic use_d);
        bit c;
        tick();
        drive(1'b1, op, 1'b0, use_d);
        #1;
        expect_outs($sformatf("%s.t0", tag), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, use_d);
        for (int k = 1; k <= n; k++) begin
            tick();
            drive(1'b0, 4'b0000, 1'b0, use_d);
            #1;
            c = (k == n);
            expect_outs($sformatf("%s.t%0d", tag, k), 1'b0, 1'b1, c, c, c, c, use_d);
            check($sformatf("%s.t%0d.dp_op", tag, k), dp_op, op);
        end
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        expect_outs($sformatf("%s.t%0d", tag, n + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        // A valid request during reset must not leak through.
        drive(1'b1, 4'b0001, 1'b0, 1'b1);
        #2;
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.dp_op", dp_op, 4'b0000);
        tick();
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        tick();

        // mult, 5 cycles, no D-stage use
        run_md("mult", 4'b0001, 5, 1'b0);

        // div, 10 cycles, D-stage use held: stall t..t+10, commit only at t+10
        run_md("div", 4'b0011, 10, 1'b1);

        // mthi then mtlo in consecutive idle cycles
        tick();
        drive(1'b1, 4'b0101, 1'b0, 1'b0);
        #1;
        expect_outs("mthi", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b0110, 1'b0, 1'b0);
        #1;
        expect_outs("mtlo", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        expect_outs("mt_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // divu flushed in its request cycle: nothing happens
        tick();
        drive(1'b1, 4'b0100, 1'b1, 1'b1);
        #1;
        expect_outs("flush_req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            drive(1'b0, 4'b0000, 1'b0, 1'b0);
            #1;
            expect_outs($sformatf("flush_idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // divu with a flush pulse during RUN still commits at t+10
        tick();
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        #1;
        check("divu_fl.t0.start", start, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            drive(1'b0, 4'b0000, (k == 3), 1'b0);
            #1;
            check($sformatf("divu_fl.t%0d.busy", k), busy, 1'b1);
            check($sformatf("divu_fl.t%0d.done", k), done, (k == 10));
            check($sformatf("divu_fl.t%0d.hi_we", k), hi_we, (k == 10));
        end
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        check("divu_fl.t11.busy", busy, 1'b0);

        // reset asserted mid-mult
        tick();
        drive(1'b1, 4'b0001, 1'b0, 1'b1);
        #1;
        check("rst_mid.t0.start", start, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        tick();
        #1;
        check("rst_mid.t2.busy", busy, 1'b1);
        check("rst_mid.t2.stall", stall, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        expect_outs("rst_mid.asserted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.dp_op", dp_op, 4'b0000);
        tick();
        #2;
        reset = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            expect_outs($sformatf("rst_after%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_md("mult_post_rst", 4'b0001, 5, 1'b0);

        // back-to-back mults at t and t+6 with an ignored div injected at t+3
        tick();
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        #1;
        check("b2b.t0.start", start, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 3) drive(1'b1, 4'b0011, 1'b0, 1'b0);
            else        drive(1'b0, 4'b0000, 1'b0, 1'b0);
            #1;
            check($sformatf("b2b.t%0d.start", k), start, 1'b0);
            check($sformatf("b2b.t%0d.busy", k), busy, 1'b1);
            check($sformatf("b2b.t%0d.done", k), done, (k == 5));
            check($sformatf("b2b.t%0d.dp_op", k), dp_op, 4'b0001);
        end
        tick();
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        #1;
        check("b2b.t6.busy", busy, 1'b0);
        check("b2b.t6.start", start, 1'b1);
        for (int k = 7; k <= 11; k++) begin
            tick();
            drive(1'b0, 4'b0000, 1'b0, 1'b0);
            #1;
            check($sformatf("b2b.t%0d.busy", k), busy, 1'b1);
            check($sformatf("b2b.t%0d.done", k), done, (k == 11));
            check($sformatf("b2b.t%0d.lo_we", k), lo_we, (k == 11));
            check($sformatf("b2b.t%0d.dp_op", k), dp_op, 4'b0010);
        end
        tick();
        #1;
        check("b2b.t12.busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
